// File: rtl/spi_slave_rx_pkg.sv
// Shared types and constants for the SPI mode-0 slave receiver.
// Holds the FSM encoding, byte geometry and the bit-order helper.
package spi_slave_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BYTE_BITS    = 8;
    localparam int SCLK_MAX_DIV = 8;

    // First bit that goes onto the wire for a given bit order.
    function automatic logic lead_bit(input logic [BYTE_BITS-1:0] v, input logic msb_first);
        return msb_first ? v[BYTE_BITS-1] : v[0];
    endfunction

endpackage

// File: rtl/spi_slave_rx_sync_edge_det.sv
// Multi-stage synchroniser for one asynchronous SPI pin, with single-clk
// rise/fall pulses derived from the last stage and one extra registered copy.
module sync_edge_det
    import spi_slave_rx_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Reset presets the chain to the idle bus level so no false edge is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the previous
            // stage's old value, which is what builds a real shift chain.
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = o_level & ~r_prev;
    assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: receives bytes on MOSI, returns i_tx_data on MISO,
// flags completed bytes and frames aborted mid-byte.
module spi_slave_rx
    import spi_slave_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_sclk,
    input  logic                 spi_cs_n,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 spi_miso_en,
    input  logic [BYTE_BITS-1:0] i_tx_data,
    output logic                 o_spi_s_rx_done,
    output logic [BYTE_BITS-1:0] r_spi_s_rx_data,
    output logic                 o_frame_err
);

    localparam int          CNT_W         = $clog2(BYTE_BITS);
    localparam logic        L_MSB         = (MSB_FIRST != 0);
    localparam logic [2:0]  SETTLE_CYCLES = 3'(SYNC_STAGES + 1);

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_mosi, w_unused_mosi_rise, w_unused_mosi_fall;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .i_async(spi_sclk),
        .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .i_async(spi_cs_n),
        .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .i_async(spi_mosi),
        .o_level(w_mosi), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
    );

    logic w_unused_sclk_level;
    assign w_unused_sclk_level = w_sclk_level;

    state_t               r_state;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [BYTE_BITS-1:0] r_rx_shift;
    logic [BYTE_BITS-1:0] r_tx_shift;
    logic                 r_armed;
    logic [2:0]           r_settle_cnt;

    logic [BYTE_BITS-1:0] w_rx_next;
    logic [BYTE_BITS-1:0] w_tx_adv;

    assign w_rx_next = L_MSB ? {r_rx_shift[BYTE_BITS-2:0], w_mosi}
                             : {w_mosi, r_rx_shift[BYTE_BITS-1:1]};
    assign w_tx_adv  = L_MSB ? {r_tx_shift[BYTE_BITS-2:0], 1'b0}
                             : {1'b0, r_tx_shift[BYTE_BITS-1:1]};

    // After reset the cs_n chain flushes from its preset; a frame already in
    // progress must end (cs_n seen high) before a new falling edge is trusted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed      <= 1'b0;
            r_settle_cnt <= '0;
        end else if (!r_armed) begin
            if (r_settle_cnt != SETTLE_CYCLES)
                r_settle_cnt <= r_settle_cnt + 3'd1;
            else if (w_cs_level)
                r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shifters are plain registers, not a memory, so they are
            // reset explicitly to give a known MISO value after reset.
            r_state         <= IDLE;
            r_bit_cnt       <= '0;
            r_rx_shift      <= '0;
            r_tx_shift      <= '0;
            r_spi_s_rx_data <= '0;
            o_spi_s_rx_done <= 1'b0;
            o_frame_err     <= 1'b0;
            spi_miso        <= 1'b0;
            spi_miso_en     <= 1'b0;
        end else begin
            o_spi_s_rx_done <= 1'b0;
            o_frame_err     <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (r_armed && w_cs_fall) begin
                        r_state     <= SHIFT;
                        r_bit_cnt   <= '0;
                        r_tx_shift  <= i_tx_data;
                        spi_miso    <= lead_bit(i_tx_data, L_MSB);
                        spi_miso_en <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_cs_rise) begin
                        r_state     <= IDLE;
                        spi_miso    <= 1'b0;
                        spi_miso_en <= 1'b0;
                        if (r_bit_cnt != '0)
                            o_frame_err <= 1'b1;
                    end else if (w_sclk_rise) begin
                        r_rx_shift <= w_rx_next;
                        r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
                        if (r_bit_cnt == CNT_W'(BYTE_BITS - 1)) begin
                            r_spi_s_rx_data <= w_rx_next;
                            o_spi_s_rx_done <= 1'b1;
                            r_state         <= DONE;
                        end
                    end else if (w_sclk_fall) begin
                        // bit_cnt==0 here means a fresh byte was just loaded.
                        if (r_bit_cnt == '0) begin
                            spi_miso <= lead_bit(r_tx_shift, L_MSB);
                        end else begin
                            r_tx_shift <= w_tx_adv;
                            spi_miso   <= lead_bit(w_tx_adv, L_MSB);
                        end
                    end
                end
                DONE: begin
                    r_tx_shift <= i_tx_data;
                    if (w_cs_level) begin
                        r_state     <= IDLE;
                        spi_miso    <= 1'b0;
                        spi_miso_en <= 1'b0;
                    end else begin
                        r_state <= SHIFT;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
